btb_predictor: RTL

BTB_PREDICTOR -- requirements
Module: btb_predictor

---
 rtl/btb_predictor.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//
// Purpose:
//   This is a direct-mapped branch target buffer with 2-bit saturating
//   counters for a two-stage (IF/ID) front end.
//   - In fetch, the table is looked up combinationally from pc_f to produce
//     the next fetch PC.
//   - In ID, the branch is resolved against the prediction that travelled
//     with the instruction. On a mismatch the fetched instruction is killed
//     and fetch is redirected.
//   - The table is trained in the same cycle as the resolution.
//
// Parameters:
//   ENTRIES  : table depth. Must be a power of two from 4 to 256.
//   INIT_CTR : counter value written when an entry is allocated.
//
// Ports:
//   clk             : single clock, rising-edge active
//   rst_n           : asynchronous active-low reset
//   pc_f            : fetch-stage PC
//   pred_pc_f       : predicted next fetch PC (combinational from pc_f)
//   pred_taken_f    : fetch predicts taken
//   stall_d         : holds the IF/ID register and blocks table/counter updates
//   branch_d        : ID instruction is a conditional branch
//   taken_d         : resolved branch outcome (ignored when branch_d=0)
//   target_d        : resolved branch target
//   flushbp         : kill the fetched instruction and redirect fetch
//   redirect_pc     : corrected fetch PC, valid while flushbp=1
//   lookup_cnt      : count of valid captures into the ID register
//   mispredict_cnt  : count of cycles with flushbp=1
// ---------------------------------------------------------------------------
module btb_predictor #(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic [31:0] pred_pc_f,
  output logic        pred_taken_f,
  input  logic        stall_d,
  input  logic        branch_d,
  input  logic        taken_d,
  input  logic [31:0] target_d,
  output logic        flushbp,
  output logic [31:0] redirect_pc,
  output logic [31:0] lookup_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  // Table storage. Only the valid bits need a reset. Tag, target and
  // counter contents are never consulted unless the valid bit is set.
  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // IF/ID prediction register
  logic        idValid_q, idValid_d;
  logic [31:0] idPc_q, idPc_d;
  logic        idHit_q, idHit_d;
  logic [31:0] idPredPc_q, idPredPc_d;

  // Performance counters
  logic [31:0] lookupCnt_q, lookupCnt_d;
  logic [31:0] mispCnt_q, mispCnt_d;

  // Fetch lookup
  logic [IDX-1:0]  fetchIdx;
  logic [TAGW-1:0] fetchTag;
  logic            fetchHit;
  logic [31:0]     fetchPcPlus4;

  // ID resolution
  logic [IDX-1:0]  idIdx;
  logic [TAGW-1:0] idTag;
  logic            idHitNow;
  logic            resolveEn;
  logic            actualTaken;
  logic [31:0]     idPcPlus4;
  logic [31:0]     actualNext;

  // Table write controls
  logic       allocEn;
  logic       invEn;
  logic       ctrWr;
  logic       tgtWr;
  logic [1:0] ctrCur;
  logic [1:0] ctrNew;

  // Fetch-side lookup. This path reads the registered table, so any write
  // made this cycle is seen by fetch only from the next cycle onward.
  always_comb begin
    fetchIdx     = pc_f[IDX+1:2];
    fetchTag     = pc_f[31:IDX+2];
    fetchHit     = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
    fetchPcPlus4 = pc_f + 32'd4;
    pred_taken_f = fetchHit && ctr_q[fetchIdx][1];
    pred_pc_f    = pred_taken_f ? target_q[fetchIdx] : fetchPcPlus4;
  end

  // ID-side resolution.
  // The fetch-time hit is re-qualified against the current table contents.
  // The previous instruction may have reallocated or invalidated the same
  // slot after this one was looked up. Counter training must never land on
  // an entry that now belongs to a different PC.
  always_comb begin
    idIdx       = idPc_q[IDX+1:2];
    idTag       = idPc_q[31:IDX+2];
    idHitNow    = idHit_q && valid_q[idIdx] && (tag_q[idIdx] == idTag);
    resolveEn   = idValid_q && !stall_d;
    actualTaken = branch_d && taken_d;
    idPcPlus4   = idPc_q + 32'd4;
    actualNext  = actualTaken ? target_d : idPcPlus4;
    redirect_pc = actualNext;
    flushbp     = resolveEn && (actualNext != idPredPc_q);
  end

  // Training decisions. The cases are mutually exclusive:
  // - train the counter on a hit branch;
  // - drop an entry that hit on a non-branch;
  // - allocate on a missed taken branch.
  always_comb begin
    allocEn = 1'b0;
    invEn   = 1'b0;
    ctrWr   = 1'b0;
    tgtWr   = 1'b0;
    ctrCur  = ctr_q[idIdx];
    ctrNew  = ctrCur;
    if (resolveEn) begin
      if (idHitNow && branch_d) begin
        ctrWr = 1'b1;
        tgtWr = taken_d;
        if (taken_d) begin
          ctrNew = (ctrCur == 2'b11) ? 2'b11 : ctrCur + 2'd1;
        end else begin
          ctrNew = (ctrCur == 2'b00) ? 2'b00 : ctrCur - 2'd1;
        end
      end else if (idHitNow && !branch_d) begin
        invEn = 1'b1;
      end else if (!idHitNow && actualTaken) begin
        allocEn = 1'b1;
      end
    end
  end

  // Next state for the IF/ID register and the counters.
  // A stall freezes everything. A flush inserts a bubble so the wrong-path
  // instruction is neither resolved nor counted as a lookup.
  always_comb begin
    idValid_d   = idValid_q;
    idPc_d      = idPc_q;
    idHit_d     = idHit_q;
    idPredPc_d  = idPredPc_q;
    lookupCnt_d = lookupCnt_q;
    mispCnt_d   = mispCnt_q;
    if (!stall_d) begin
      if (flushbp) begin
        idValid_d = 1'b0;
        mispCnt_d = mispCnt_q + 32'd1;
      end else begin
        idValid_d   = 1'b1;
        idPc_d      = pc_f;
        idHit_d     = fetchHit;
        idPredPc_d  = pred_pc_f;
        lookupCnt_d = lookupCnt_q + 32'd1;
      end
    end
  end

  // IF/ID register and counters. An asynchronous reset clears the valid bit,
  // so a resolution in progress produces no flush and no table write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idValid_q   <= 1'b0;
      idPc_q      <= 32'd0;
      idHit_q     <= 1'b0;
      idPredPc_q  <= 32'd0;
      lookupCnt_q <= 32'd0;
      mispCnt_q   <= 32'd0;
    end else begin
      idValid_q   <= idValid_d;
      idPc_q      <= idPc_d;
      idHit_q     <= idHit_d;
      idPredPc_q  <= idPredPc_d;
      lookupCnt_q <= lookupCnt_d;
      mispCnt_q   <= mispCnt_d;
    end
  end

  // Valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (allocEn) begin
      valid_q[idIdx] <= 1'b1;
    end else if (invEn) begin
      valid_q[idIdx] <= 1'b0;
    end
  end

  // Tag, target and counter storage. This block has no reset because the
  // valid bits gate every use of these fields.
  always_ff @(posedge clk) begin
    if (allocEn) begin
      tag_q[idIdx]    <= idTag;
      target_q[idIdx] <= target_d;
      ctr_q[idIdx]    <= INIT_CTR;
    end else begin
      if (ctrWr) begin
        ctr_q[idIdx] <= ctrNew;
      end
      if (tgtWr) begin
        target_q[idIdx] <= target_d;
      end
    end
  end

  assign lookup_cnt     = lookupCnt_q;
  assign mispredict_cnt = mispCnt_q;

endmodule
